// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg
// Shared types and helpers for the AXIS packet FIFO.
//   drop_state_t    : write-side state when whole-packet dropping is enabled
//   axis_word_width : bits needed to store one AXIS beat
//                     (tdata + tkeep + tlast + tid + tdest + tuser)
package axis_fifo_pkg;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } drop_state_t;

  // tdata is 8 bits per byte and tkeep is 1 bit per byte, hence 9 bits per byte.
  function automatic int axis_word_width(input int data_bytes, input int id_w,
                                         input int dest_w, input int user_w);
    return 32'd9 * data_bytes + 32'd1 + id_w + dest_w + user_w;
  endfunction

endpackage

// File: rtl/AXIS_int.sv
// AXIS_int
// AXI4-Stream bundle with a clock.
//   clk                               : stream clock
//   tvalid/tready                     : handshake
//   tdata/tkeep/tstrb/tlast           : payload and framing
//   tid/tdest/tuser                   : sideband
// Master drives the payload and samples tready; Slave is the reverse.
interface AXIS_int #(
  parameter int DATA_BYTES = 8,
  parameter int ID_W       = 4,
  parameter int DEST_W     = 4,
  parameter int USER_W     = 1
) (
  input logic clk
);
  logic                    tvalid;
  logic                    tready;
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic [DATA_BYTES-1:0]   tstrb;
  logic                    tlast;
  logic [ID_W-1:0]         tid;
  logic [DEST_W-1:0]       tdest;
  logic [USER_W-1:0]       tuser;

  modport Master (input clk, input tready,
                  output tvalid, output tdata, output tkeep, output tstrb,
                  output tlast, output tid, output tdest, output tuser);

  modport Slave  (input clk, input tvalid, input tdata, input tkeep, input tstrb,
                  input tlast, input tid, input tdest, input tuser,
                  output tready);
endinterface

// File: rtl/dist_ram_sdp.sv
// dist_ram_sdp
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
module dist_ram_sdp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: storage is not reset, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
// Single-clock AXIS FIFO with optional store-and-forward packet mode and
// whole-packet drop when full.
//   clk          : clock, same as axis_in.clk / axis_out.clk
//   sreset       : synchronous active-high reset
//   axis_in      : input stream (tstrb is not stored)
//   axis_out     : output stream (tstrb driven all ones)
//   pkt_dropped  : one-cycle pulse per dropped packet
//   pkt_oversize : one-cycle pulse when a packet that fills the FIFO is force-committed
//   drop_count   : saturating count of dropped packets
//   fill_words   : written-but-unread words, uncommitted ones included
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int PACKET_MODE    = 1,
  parameter int DROP_WHEN_FULL = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       sreset,
  AXIS_int.Slave                     axis_in,
  AXIS_int.Master                    axis_out,
  output logic                       pkt_dropped,
  output logic                       pkt_oversize,
  output logic [DROP_CNT_WIDTH-1:0]  drop_count,
  output logic [$clog2(DEPTH+1)-1:0] fill_words
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam int DB = $bits(axis_in.tkeep);
  localparam int IW = $bits(axis_in.tid);
  localparam int SW = $bits(axis_in.tdest);
  localparam int UW = $bits(axis_in.tuser);
  localparam int WW = axis_word_width(DB, IW, SW, UW);

  // Dropping needs commit points to rewind to, which only packet mode maintains.
  if (DROP_WHEN_FULL != 0 && PACKET_MODE == 0) begin : g_bad_cfg
    $error("axis_pkt_fifo: DROP_WHEN_FULL=1 requires PACKET_MODE=1");
  end

  logic [PW-1:0]             wr_ptr_r;
  logic [PW-1:0]             commit_ptr_r;
  logic [PW-1:0]             rd_ptr_r;
  drop_state_t               state_r;
  logic                      forced_r;
  logic                      pkt_dropped_r;
  logic                      pkt_oversize_r;
  logic [DROP_CNT_WIDTH-1:0] drop_count_r;

  logic [PW-1:0] vis_s;
  logic          full_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          pop_s;
  logic          write_s;
  logic          drop_s;
  logic          force_s;
  logic [WW-1:0] wdata_s;
  logic [WW-1:0] rdata_s;
  logic          unused_s;

  // Occupancy and handshake decode, all from registered pointers.
  always_comb begin
    full_s      = (wr_ptr_r - rd_ptr_r) == PW'(DEPTH);
    vis_s       = (PACKET_MODE != 0) ? commit_ptr_r : wr_ptr_r;
    out_valid_s = (rd_ptr_r != vis_s);
    pop_s       = out_valid_s && axis_out.tready;
    in_ready_s  = (DROP_WHEN_FULL != 0) ? 1'b1 : !full_s;
    // In drop mode a beat arriving at full is never written, even if a pop happens this cycle.
    write_s     = axis_in.tvalid && in_ready_s && !full_s && (state_r == ACCEPT);
    drop_s      = (DROP_WHEN_FULL != 0) && axis_in.tvalid && full_s && (state_r == ACCEPT);
    // Nothing readable and no room left: release the partial packet to avoid deadlock.
    force_s     = (PACKET_MODE != 0) && (DROP_WHEN_FULL == 0) && full_s &&
                  (commit_ptr_r == rd_ptr_r);
  end

  // Pointers, drop FSM and status pulses.
  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr_r       <= '0;
      commit_ptr_r   <= '0;
      rd_ptr_r       <= '0;
      state_r        <= ACCEPT;
      forced_r       <= 1'b0;
      pkt_dropped_r  <= 1'b0;
      pkt_oversize_r <= 1'b0;
      drop_count_r   <= '0;
    end else begin
      pkt_dropped_r  <= 1'b0;
      pkt_oversize_r <= 1'b0;

      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end

      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
        // After a forced commit the tail of that packet is published beat by beat.
        if (axis_in.tlast || forced_r) begin
          commit_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (axis_in.tlast) begin
          forced_r <= 1'b0;
        end
      end else if (drop_s) begin
        wr_ptr_r      <= commit_ptr_r;
        pkt_dropped_r <= 1'b1;
        if (drop_count_r != {DROP_CNT_WIDTH{1'b1}}) begin
          drop_count_r <= drop_count_r + DROP_CNT_WIDTH'(1);
        end
      end else if (force_s) begin
        commit_ptr_r   <= wr_ptr_r;
        forced_r       <= 1'b1;
        pkt_oversize_r <= !forced_r;
      end

      case (state_r)
        ACCEPT: begin
          if (drop_s && !axis_in.tlast) begin
            state_r <= DROP;
          end
        end
        DROP: begin
          if (axis_in.tvalid && axis_in.tlast) begin
            state_r <= ACCEPT;
          end
        end
        default: state_r <= ACCEPT;
      endcase
    end
  end

  assign wdata_s = {axis_in.tdata, axis_in.tkeep, axis_in.tlast,
                    axis_in.tid, axis_in.tdest, axis_in.tuser};

  dist_ram_sdp #(.WIDTH(WW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (write_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (wdata_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rdata_s)
  );

  assign {axis_out.tdata, axis_out.tkeep, axis_out.tlast,
          axis_out.tid, axis_out.tdest, axis_out.tuser} = rdata_s;
  assign axis_out.tstrb  = '1;
  assign axis_out.tvalid = out_valid_s;
  assign axis_in.tready  = in_ready_s;

  assign pkt_dropped  = pkt_dropped_r;
  assign pkt_oversize = pkt_oversize_r;
  assign drop_count   = drop_count_r;
  assign fill_words   = FW'(wr_ptr_r - rd_ptr_r);

  assign unused_s = ^{axis_in.tstrb, axis_in.clk, axis_out.clk};

endmodule

// File: tb/tb_axis_pkt_fifo.sv
module tb_axis_pkt_fifo;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic        user;
  } beat_t;

  logic        clk = 1'b0;
  logic        sreset;
  logic        dropped_a, over_a, dropped_b, over_b;
  logic [15:0] cnt_a, cnt_b;
  logic [5:0]  fill_a, fill_b;

  always #5 clk = ~clk;

  AXIS_int #(.DATA_BYTES(8), .ID_W(4), .DEST_W(4), .USER_W(1)) in_a  (.clk(clk));
  AXIS_int #(.DATA_BYTES(8), .ID_W(4), .DEST_W(4), .USER_W(1)) out_a (.clk(clk));
  AXIS_int #(.DATA_BYTES(8), .ID_W(4), .DEST_W(4), .USER_W(1)) in_b  (.clk(clk));
  AXIS_int #(.DATA_BYTES(8), .ID_W(4), .DEST_W(4), .USER_W(1)) out_b (.clk(clk));

  axis_pkt_fifo #(.DEPTH(32), .PACKET_MODE(1), .DROP_WHEN_FULL(1), .DROP_CNT_WIDTH(16)) dut_a (
    .clk(clk), .sreset(sreset), .axis_in(in_a), .axis_out(out_a),
    .pkt_dropped(dropped_a), .pkt_oversize(over_a), .drop_count(cnt_a), .fill_words(fill_a));

  axis_pkt_fifo #(.DEPTH(32), .PACKET_MODE(1), .DROP_WHEN_FULL(0), .DROP_CNT_WIDTH(16)) dut_b (
    .clk(clk), .sreset(sreset), .axis_in(in_b), .axis_out(out_b),
    .pkt_dropped(dropped_b), .pkt_oversize(over_b), .drop_count(cnt_b), .fill_words(fill_b));

  // Reference model: readable words, written-but-uncommitted words, and packet-level flags.
  beat_t       mq   [2][$];
  beat_t       pend [2][$];
  bit          dropping [2];
  bit          forced   [2];
  logic [15:0] m_cnt    [2];
  bit          m_dp     [2];
  bit          m_op     [2];

  int n_checks = 0;
  int n_fail   = 0;
  int beats  [2];
  int lasts  [2];
  int dpulse [2];
  int opulse [2];
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t mk_beat(input int pkt, input int idx, input int nw, input int lb,
                                    input bit has_last);
    beat_t b;
    b.data = {32'(pkt), 32'(idx)} ^ 64'hC3C3_0000_3C3C_0000;
    b.last = has_last && (idx == nw - 1);
    b.keep = b.last ? 8'(8'hFF >> (8 - lb)) : 8'hFF;
    b.id   = 4'(pkt);
    b.dest = 4'(idx);
    b.user = 1'(idx);
    return b;
  endfunction

  task automatic commit_pend(input int d);
    while (pend[d].size() != 0) mq[d].push_back(pend[d].pop_front());
  endtask

  // d=0: drop-when-full FIFO; d=1: backpressure FIFO with forced commit.
  task automatic model_step(input int d, input logic rst, input logic iv, input beat_t b,
                            input logic ordy);
    bit full, vis_empty;
    m_dp[d] = 1'b0;
    m_op[d] = 1'b0;
    if (rst) begin
      mq[d].delete(); pend[d].delete();
      dropping[d] = 1'b0; forced[d] = 1'b0; m_cnt[d] = 16'd0;
      return;
    end
    full      = (mq[d].size() + pend[d].size()) == 32;
    vis_empty = (mq[d].size() == 0);
    if (!vis_empty && ordy) void'(mq[d].pop_front());
    if (d == 0) begin
      if (iv) begin
        if (dropping[d]) begin
          if (b.last) dropping[d] = 1'b0;
        end else if (full) begin
          pend[d].delete();
          m_dp[d] = 1'b1;
          if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
          if (!b.last) dropping[d] = 1'b1;
        end else begin
          pend[d].push_back(b);
          if (b.last) commit_pend(d);
        end
      end
    end else begin
      if (iv && !full) begin
        if (forced[d]) begin
          mq[d].push_back(b);
          if (b.last) forced[d] = 1'b0;
        end else begin
          pend[d].push_back(b);
          if (b.last) commit_pend(d);
        end
      end else if (full && vis_empty && !forced[d]) begin
        commit_pend(d);
        forced[d] = 1'b1;
        m_op[d]   = 1'b1;
      end
    end
  endtask

  task automatic compare_one(input int d, input logic v, input beat_t ob, input logic [7:0] strb,
                             input logic [5:0] fill, input logic [15:0] cnt, input logic dp,
                             input logic op, input logic irdy, input logic ordy);
    int total = mq[d].size() + pend[d].size();
    chk($sformatf("d%0d_tvalid", d), v, mq[d].size() != 0);
    if (v && mq[d].size() != 0) begin
      chk($sformatf("d%0d_tdata", d), ob.data, mq[d][0].data);
      chk($sformatf("d%0d_tkeep", d), ob.keep, mq[d][0].keep);
      chk($sformatf("d%0d_tlast", d), ob.last, mq[d][0].last);
      chk($sformatf("d%0d_side", d), {ob.id, ob.dest, ob.user},
          {mq[d][0].id, mq[d][0].dest, mq[d][0].user});
      chk($sformatf("d%0d_tstrb", d), strb, 8'hFF);
    end
    chk($sformatf("d%0d_fill", d), fill, total);
    chk($sformatf("d%0d_drop_count", d), cnt, m_cnt[d]);
    chk($sformatf("d%0d_pkt_dropped", d), dp, m_dp[d]);
    chk($sformatf("d%0d_pkt_oversize", d), op, m_op[d]);
    chk($sformatf("d%0d_in_tready", d), irdy, (d == 0) ? 1'b1 : (total < 32));
    if (v && ordy) begin
      beats[d]++;
      if (ob.last) lasts[d]++;
    end
    if (dp) dpulse[d]++;
    if (op) opulse[d]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input beat_t b);
    in_a.tvalid = v; in_a.tdata = b.data; in_a.tkeep = b.keep; in_a.tstrb = b.keep;
    in_a.tlast = b.last; in_a.tid = b.id; in_a.tdest = b.dest; in_a.tuser = b.user;
  endtask

  task automatic drive_b(input logic v, input beat_t b);
    in_b.tvalid = v; in_b.tdata = b.data; in_b.tkeep = b.keep; in_b.tstrb = b.keep;
    in_b.tlast = b.last; in_b.tid = b.id; in_b.tdest = b.dest; in_b.tuser = b.user;
  endtask

  // Beat with handshake on the backpressure FIFO, bounded wait.
  task automatic send_b(input beat_t b);
    int n = 0;
    bit acc = 1'b0;
    drive_b(1'b1, b);
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_b.tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_push_accepted", acc, 1'b1);
  endtask

  task automatic send_pkt_a(input int pkt, input int nw, input int lb, input bit has_last);
    for (int i = 0; i < nw; i++) begin
      drive_a(1'b1, mk_beat(pkt, i, nw, lb, has_last));
      tick();
    end
    drive_a(1'b0, '0);
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (mq[d].size() != 0 && n < 600) begin
      tick();
      n++;
    end
    tick();
    chk($sformatf("d%0d_drain_in_time", d), n < 600, 1'b1);
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      beats[d] = 0; lasts[d] = 0; dpulse[d] = 0; opulse[d] = 0;
    end
  endtask

  initial begin
    sreset = 1'b1;
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    out_a.tready = 1'b1;
    out_b.tready = 1'b1;
    fork
      forever begin
        @(posedge clk);
        model_step(0, sreset, in_a.tvalid,
                   beat_t'({in_a.tdata, in_a.tkeep, in_a.tlast, in_a.tid, in_a.tdest, in_a.tuser}),
                   out_a.tready);
        model_step(1, sreset, in_b.tvalid,
                   beat_t'({in_b.tdata, in_b.tkeep, in_b.tlast, in_b.tid, in_b.tdest, in_b.tuser}),
                   out_b.tready);
      end
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          compare_one(0, out_a.tvalid,
                      beat_t'({out_a.tdata, out_a.tkeep, out_a.tlast, out_a.tid, out_a.tdest, out_a.tuser}),
                      out_a.tstrb, fill_a, cnt_a, dropped_a, over_a, in_a.tready, out_a.tready);
          compare_one(1, out_b.tvalid,
                      beat_t'({out_b.tdata, out_b.tkeep, out_b.tlast, out_b.tid, out_b.tdest, out_b.tuser}),
                      out_b.tstrb, fill_b, cnt_b, dropped_b, over_b, in_b.tready, out_b.tready);
        end
      end
      begin
        #1000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "tb_axis_pkt_fifo timeout");
      end
    join_none

    tick(); tick();
    do_reset();
    cmp_en = 1'b1;
    chk("rst_tvalid_a", out_a.tvalid, 1'b0);
    chk("rst_fill_a", fill_a, 6'd0);
    chk("rst_cnt_a", cnt_a, 16'd0);
    chk("rst_tready_a", in_a.tready, 1'b1);
    chk("rst_tready_b", in_b.tready, 1'b1);
    chk("rst_tvalid_b", out_b.tvalid, 1'b0);

    // 1. smoke: 100 packets of 8..200 bytes, sink always ready.
    for (int p = 0; p < 100; p++) begin
      int bytes = 8 + (p * 37) % 193;
      int nw = (bytes + 7) / 8;
      send_pkt_a(p, nw, bytes - 8 * (nw - 1), 1'b1);
    end
    drain(0);
    chk("smoke_lasts", lasts[0], 100);
    chk("smoke_drop_count", cnt_a, 16'd0);

    // 2. store-and-forward: 10 beats with a one-cycle gap after each.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, mk_beat(200, i, 10, 8, 1'b1));
      tick();
      drive_a(1'b0, '0);
      if (i < 9) begin
        tick();
        chk("sf_hold_tvalid", out_a.tvalid, 1'b0);
      end
    end
    for (int k = 0; k < 10; k++) begin
      chk("sf_burst_tvalid", out_a.tvalid, 1'b1);
      tick();
    end
    chk("sf_after_tvalid", out_a.tvalid, 1'b0);
    chk("sf_beats", beats[0], 10);

    // 3. drop on full: three 12-word packets into a stalled sink.
    do_reset();
    out_a.tready = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt_a(300 + p, 12, 8, 1'b1);
    tick();
    chk("full_fill", fill_a, 6'd24);
    chk("full_drop_count", cnt_a, 16'd1);
    chk("full_drop_pulses", dpulse[0], 1);
    out_a.tready = 1'b1;
    drain(0);
    chk("full_beats", beats[0], 24);
    chk("full_lasts", lasts[0], 2);

    // 4. oversize drop: 40-word packet, then a 5-word packet.
    do_reset();
    send_pkt_a(400, 40, 8, 1'b1);
    tick();
    chk("over_fill", fill_a, 6'd0);
    chk("over_drop_count", cnt_a, 16'd1);
    send_pkt_a(401, 5, 3, 1'b1);
    drain(0);
    chk("over_next_beats", beats[0], 5);
    chk("over_next_lasts", lasts[0], 1);

    // 5. forced commit on the backpressure FIFO.
    do_reset();
    out_b.tready = 1'b0;
    for (int i = 0; i < 32; i++) send_b(mk_beat(500, i, 40, 8, 1'b1));
    drive_b(1'b0, '0);
    tick(); tick();
    chk("force_tready", in_b.tready, 1'b0);
    chk("force_fill", fill_b, 6'd32);
    chk("force_pulses", opulse[1], 1);
    chk("force_tvalid", out_b.tvalid, 1'b1);
    out_b.tready = 1'b1;
    for (int i = 32; i < 40; i++) send_b(mk_beat(500, i, 40, 8, 1'b1));
    drive_b(1'b0, '0);
    drain(1);
    chk("force_beats", beats[1], 40);
    chk("force_lasts", lasts[1], 1);
    chk("force_no_drop", dpulse[1], 0);

    // 6. reset in the middle of a packet.
    do_reset();
    send_pkt_a(600, 5, 8, 1'b0);
    do_reset();
    chk("midrst_tvalid", out_a.tvalid, 1'b0);
    chk("midrst_fill", fill_a, 6'd0);
    chk("midrst_cnt", cnt_a, 16'd0);
    send_pkt_a(601, 6, 8, 1'b1);
    drain(0);
    chk("midrst_beats", beats[0], 6);
    chk("midrst_lasts", lasts[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
